// File: rtl/scoreboard_display_sequencer.sv
// scoreboard_display_sequencer
//
// Drives the shared 7-segment digit bus for an N-player scoreboard. Each
// player in turn gets BLINK_COUNT on/off blinks of their player number on
// digit 0, followed by their score from the most significant non-zero digit
// down to the ones digit. The score is snapshotted when the player's first
// blink starts and converted to BCD by a sequential double-dabble. Scores too
// large for the display show as all nines.
//
// Ports:
//   clk_i            : clock
//   rst_i            : asynchronous active-high reset
//   enable_i         : run; low forces IDLE with a blank display
//   scores_i         : packed scores, player p at [p*SCORE_W +: SCORE_W]
//   digit_o          : BCD digit or player number, 4'hF = blank
//   segment_select_o : one-hot digit enable, all zero = none
//   player_o         : 0-based index of the player being sequenced
//   state_o          : 0 IDLE, 1 BLINK_ON, 2 BLINK_OFF, 3 DIGIT
//   frame_done_o     : one-cycle pulse when sequencing wraps back to player 0

module scoreboard_display_sequencer #(
  parameter int N_PLAYERS    = 2,
  parameter int SCORE_W      = 8,
  parameter int N_DIGITS     = 3,
  parameter int BLINK_HALF   = 1_048_576,
  parameter int BLINK_COUNT  = 3,
  parameter int DIGIT_CYCLES = 1_048_576
) (
  input  logic                           clk_i,
  input  logic                           rst_i,
  input  logic                           enable_i,
  input  logic [N_PLAYERS*SCORE_W-1:0]   scores_i,
  output logic [3:0]                     digit_o,
  output logic [N_DIGITS-1:0]            segment_select_o,
  output logic [3:0]                     player_o,
  output logic [1:0]                     state_o,
  output logic                           frame_done_o
);

  localparam int PH_MAX = (BLINK_HALF > DIGIT_CYCLES) ? BLINK_HALF : DIGIT_CYCLES;
  localparam int PH_W   = $clog2(PH_MAX + 1);
  localparam int BL_W   = $clog2(BLINK_COUNT + 1);
  localparam int K_W    = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
  localparam int CV_W   = $clog2(SCORE_W + 2);
  localparam int BCD_W  = 4 * N_DIGITS;

  localparam logic [PH_W-1:0]     BH_LAST     = PH_W'(BLINK_HALF - 1);
  localparam logic [PH_W-1:0]     DC_LAST     = PH_W'(DIGIT_CYCLES - 1);
  localparam logic [BL_W-1:0]     BC_LAST     = BL_W'(BLINK_COUNT - 1);
  localparam logic [3:0]          LAST_PLAYER = 4'(N_PLAYERS - 1);
  localparam logic [CV_W-1:0]     SHIFT_LAST  = CV_W'(SCORE_W);
  localparam logic [N_DIGITS-1:0] SEL_ONES    = N_DIGITS'(1);
  localparam logic [BCD_W-1:0]    ALL_NINES   = {N_DIGITS{4'd9}};

  // The BCD conversion must finish before the digit phase begins.
  if (2 * BLINK_HALF * BLINK_COUNT < SCORE_W + 2) begin : g_blink_too_short
    $error("blink phases too short to cover the BCD conversion");
  end

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    BLINK_ON  = 2'd1,
    BLINK_OFF = 2'd2,
    DIGIT     = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic [PH_W-1:0]   phase_q, phase_d;
  logic [BL_W-1:0]   blink_q, blink_d;
  logic [K_W-1:0]    k_q, k_d;
  logic [3:0]        player_d;
  logic [3:0]        digit_d;
  logic [N_DIGITS-1:0] sel_d;
  logic              frame_d;
  logic              load_snap;
  logic              clear_all;

  logic [3:0]        next_player;
  logic              last_player;
  logic [K_W-1:0]    top_k;
  logic [SCORE_W-1:0] snap_slice;

  // Conversion datapath. snap_q rotates through itself during conversion so
  // that after SCORE_W shifts it again holds the snapshot.
  logic [SCORE_W-1:0]          snap_q;
  logic [BCD_W-1:0]            bcd_work;
  logic [BCD_W-1:0]            bcd_adj;
  logic                        overflow_q;
  logic [CV_W-1:0]             conv_cnt;
  logic                        conv_busy;
  logic [N_DIGITS-1:0][3:0]    bcd_digits;

  assign state_o     = state_q;
  assign last_player = (player_o == LAST_PLAYER);
  assign next_player = last_player ? 4'd0 : player_o + 4'd1;

  // Highest non-zero BCD digit; digit 0 is always shown so zero displays "0".
  always_comb begin
    top_k = '0;
    for (int i = 1; i < N_DIGITS; i++) begin
      if (bcd_digits[i] != 4'd0) top_k = K_W'(i);
    end
  end

  // Score slice of the player about to start its first blink.
  always_comb begin
    snap_slice = '0;
    for (int p = 0; p < N_PLAYERS; p++) begin
      if (player_d == 4'(p)) snap_slice = scores_i[p*SCORE_W +: SCORE_W];
    end
  end

  // Double-dabble add-3 step. Only N_DIGITS digits are kept: the bit that
  // falls off the top on a shift means the value no longer fits, which is
  // exactly the saturation condition.
  always_comb begin
    bcd_adj = bcd_work;
    for (int i = 0; i < N_DIGITS; i++) begin
      if (bcd_work[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = bcd_work[4*i +: 4] + 4'd3;
    end
  end

  // Next-state and next-output logic; outputs are registered from these.
  always_comb begin
    state_d   = state_q;
    phase_d   = phase_q;
    blink_d   = blink_q;
    k_d       = k_q;
    player_d  = player_o;
    digit_d   = digit_o;
    sel_d     = segment_select_o;
    frame_d   = 1'b0;
    load_snap = 1'b0;
    clear_all = 1'b0;
    if (!enable_i) begin
      state_d   = IDLE;
      phase_d   = '0;
      blink_d   = '0;
      k_d       = '0;
      player_d  = '0;
      digit_d   = 4'hF;
      sel_d     = '0;
      clear_all = 1'b1;
    end else begin
      case (state_q)
        IDLE: begin
          state_d   = BLINK_ON;
          phase_d   = '0;
          blink_d   = '0;
          k_d       = '0;
          player_d  = '0;
          digit_d   = 4'd1;
          sel_d     = SEL_ONES;
          load_snap = 1'b1;
        end
        BLINK_ON: begin
          if (phase_q == BH_LAST) begin
            state_d = BLINK_OFF;
            phase_d = '0;
            digit_d = 4'hF;
          end else begin
            phase_d = phase_q + PH_W'(1);
          end
        end
        BLINK_OFF: begin
          if (phase_q == BH_LAST) begin
            phase_d = '0;
            if (blink_q == BC_LAST) begin
              state_d = DIGIT;
              blink_d = '0;
              k_d     = top_k;
              digit_d = bcd_digits[top_k];
              sel_d   = SEL_ONES << top_k;
            end else begin
              state_d = BLINK_ON;
              blink_d = blink_q + BL_W'(1);
              digit_d = player_o + 4'd1;
            end
          end else begin
            phase_d = phase_q + PH_W'(1);
          end
        end
        DIGIT: begin
          if (phase_q == DC_LAST) begin
            phase_d = '0;
            if (k_q == '0) begin
              state_d   = BLINK_ON;
              player_d  = next_player;
              frame_d   = last_player;
              digit_d   = next_player + 4'd1;
              sel_d     = SEL_ONES;
              load_snap = 1'b1;
            end else begin
              k_d     = k_q - K_W'(1);
              digit_d = bcd_digits[k_d];
              sel_d   = SEL_ONES << k_d;
            end
          end else begin
            phase_d = phase_q + PH_W'(1);
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // Sequencer state and registered outputs.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q          <= IDLE;
      phase_q          <= '0;
      blink_q          <= '0;
      k_q              <= '0;
      player_o         <= '0;
      digit_o          <= 4'hF;
      segment_select_o <= '0;
      frame_done_o     <= 1'b0;
    end else begin
      state_q          <= state_d;
      phase_q          <= phase_d;
      blink_q          <= blink_d;
      k_q              <= k_d;
      player_o         <= player_d;
      digit_o          <= digit_d;
      segment_select_o <= sel_d;
      frame_done_o     <= frame_d;
    end
  end

  // Snapshot and sequential BCD conversion: SCORE_W shift cycles, then one
  // cycle that publishes the digits (or all nines on overflow).
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      snap_q     <= '0;
      bcd_work   <= '0;
      overflow_q <= 1'b0;
      conv_cnt   <= '0;
      conv_busy  <= 1'b0;
      bcd_digits <= '0;
    end else if (clear_all) begin
      snap_q     <= '0;
      bcd_work   <= '0;
      overflow_q <= 1'b0;
      conv_cnt   <= '0;
      conv_busy  <= 1'b0;
      bcd_digits <= '0;
    end else if (load_snap) begin
      snap_q     <= snap_slice;
      bcd_work   <= '0;
      overflow_q <= 1'b0;
      conv_cnt   <= '0;
      conv_busy  <= 1'b1;
    end else if (conv_busy) begin
      if (conv_cnt == SHIFT_LAST) begin
        conv_busy  <= 1'b0;
        bcd_digits <= overflow_q ? ALL_NINES : bcd_work;
      end else begin
        bcd_work   <= {bcd_adj[BCD_W-2:0], snap_q[SCORE_W-1]};
        overflow_q <= overflow_q | bcd_adj[BCD_W-1];
        snap_q     <= (snap_q << 1) | (snap_q >> (SCORE_W - 1));
        conv_cnt   <= conv_cnt + CV_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_scoreboard_display_sequencer.sv
// Directed self-checking bench for scoreboard_display_sequencer. A three-player,
// three-digit instance covers the main frame sequence, snapshot holding,
// enable drop and asynchronous reset; a one-player, two-digit instance covers
// saturation and the zero score.

module tb_scoreboard_display_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        enable1;
  logic [23:0] scores1;
  logic [3:0]  digit1;
  logic [2:0]  sel1;
  logic [3:0]  player1;
  logic [1:0]  state1;
  logic        fd1;

  logic        enable2;
  logic [7:0]  score2;
  logic [3:0]  digit2;
  logic [1:0]  sel2;
  logic [3:0]  player2;
  logic [1:0]  state2;
  logic        fd2;

  int check_count = 0;
  int pass_count  = 0;

  typedef struct {
    logic [1:0] st;
    logic [3:0] dig;
    logic [2:0] sel;
    logic [3:0] ply;
    logic       fd;
    int         n;
  } phase_t;

  phase_t exp_q[$];

  always #5 clk = ~clk;

  scoreboard_display_sequencer #(
    .N_PLAYERS(3), .SCORE_W(8), .N_DIGITS(3),
    .BLINK_HALF(4), .BLINK_COUNT(2), .DIGIT_CYCLES(5)
  ) dut (
    .clk_i(clk), .rst_i(rst), .enable_i(enable1), .scores_i(scores1),
    .digit_o(digit1), .segment_select_o(sel1), .player_o(player1),
    .state_o(state1), .frame_done_o(fd1)
  );

  scoreboard_display_sequencer #(
    .N_PLAYERS(1), .SCORE_W(8), .N_DIGITS(2),
    .BLINK_HALF(4), .BLINK_COUNT(2), .DIGIT_CYCLES(5)
  ) dut_small (
    .clk_i(clk), .rst_i(rst), .enable_i(enable2), .scores_i(score2),
    .digit_o(digit2), .segment_select_o(sel2), .player_o(player2),
    .state_o(state2), .frame_done_o(fd2)
  );

  function automatic void push_phase(input logic [1:0] st, input logic [3:0] dig,
                                     input logic [2:0] sel, input logic [3:0] ply,
                                     input logic fd, input int n);
    phase_t ph;
    ph.st = st; ph.dig = dig; ph.sel = sel; ph.ply = ply; ph.fd = fd; ph.n = n;
    exp_q.push_back(ph);
  endfunction

  // Two on/off blink pairs of four cycles each on digit 0.
  function automatic void push_blinks(input logic [3:0] ply, input logic fd);
    push_phase(2'd1, ply + 4'd1, 3'b001, ply, fd,   4);
    push_phase(2'd2, 4'hF,       3'b001, ply, 1'b0, 4);
    push_phase(2'd1, ply + 4'd1, 3'b001, ply, 1'b0, 4);
    push_phase(2'd2, 4'hF,       3'b001, ply, 1'b0, 4);
  endfunction

  task automatic apply_reset();
    rst     = 1'b1;
    enable1 = 1'b0;
    enable2 = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic [13:0] got_t;
    rst = 1'b1; enable1 = 1'b0; enable2 = 1'b0;
    scores1 = 24'd0; score2 = 8'd0;
    #3;
    got_t = {state1, digit1, sel1, player1, fd1};
    check_count++;
    if (got_t !== {2'd0, 4'hF, 3'b000, 4'd0, 1'b0})
      $display("[TB] FAIL reset_main: got %h expected %h", got_t, {2'd0, 4'hF, 3'b000, 4'd0, 1'b0});
    else pass_count++;
    got_t = {state2, digit2, 1'b0, sel2, player2, fd2};
    check_count++;
    if (got_t !== {2'd0, 4'hF, 3'b000, 4'd0, 1'b0})
      $display("[TB] FAIL reset_small: got %h expected %h", got_t, {2'd0, 4'hF, 3'b000, 4'd0, 1'b0});
    else pass_count++;
    @(posedge clk);
    #1 rst = 1'b0;
    for (int c = 0; c < 50; c++) begin
      @(posedge clk); #1;
      got_t = {state1, digit1, sel1, player1, fd1};
      check_count++;
      if (got_t !== {2'd0, 4'hF, 3'b000, 4'd0, 1'b0})
        $display("[TB] FAIL idle_hold cycle %0d: got %h expected %h", c, got_t, {2'd0, 4'hF, 3'b000, 4'd0, 1'b0});
      else pass_count++;
    end
  endtask

  task automatic test_frame();
    logic [13:0] got_t, exp_t;
    apply_reset();
    scores1 = {8'd205, 8'd42, 8'd7};
    exp_q.delete();
    push_blinks(4'd0, 1'b0);
    push_phase(2'd3, 4'd7, 3'b001, 4'd0, 1'b0, 5);
    push_blinks(4'd1, 1'b0);
    push_phase(2'd3, 4'd4, 3'b010, 4'd1, 1'b0, 5);
    push_phase(2'd3, 4'd2, 3'b001, 4'd1, 1'b0, 5);
    push_blinks(4'd2, 1'b0);
    push_phase(2'd3, 4'd2, 3'b100, 4'd2, 1'b0, 5);
    push_phase(2'd3, 4'd0, 3'b010, 4'd2, 1'b0, 5);
    push_phase(2'd3, 4'd5, 3'b001, 4'd2, 1'b0, 5);
    push_phase(2'd1, 4'd1, 3'b001, 4'd0, 1'b1, 1);
    push_phase(2'd1, 4'd1, 3'b001, 4'd0, 1'b0, 3);
    enable1 = 1'b1;
    for (int i = 0; i < exp_q.size(); i++) begin
      for (int c = 0; c < exp_q[i].n; c++) begin
        @(posedge clk); #1;
        exp_t = {exp_q[i].st, exp_q[i].dig, exp_q[i].sel, exp_q[i].ply, (c == 0) ? exp_q[i].fd : 1'b0};
        got_t = {state1, digit1, sel1, player1, fd1};
        check_count++;
        if (got_t !== exp_t)
          $display("[TB] FAIL frame phase %0d cycle %0d: got %h expected %h", i, c, got_t, exp_t);
        else pass_count++;
      end
    end
  endtask

  task automatic test_small_display();
    logic [13:0] got_t, exp_t;
    int change_idx;
    apply_reset();
    score2 = 8'd255;
    exp_q.delete();
    push_blinks(4'd0, 1'b0);
    push_phase(2'd3, 4'd9, 3'b010, 4'd0, 1'b0, 5);
    change_idx = exp_q.size();
    push_phase(2'd3, 4'd9, 3'b001, 4'd0, 1'b0, 5);
    push_blinks(4'd0, 1'b1);
    push_phase(2'd3, 4'd0, 3'b001, 4'd0, 1'b0, 5);
    push_phase(2'd1, 4'd1, 3'b001, 4'd0, 1'b1, 1);
    enable2 = 1'b1;
    for (int i = 0; i < exp_q.size(); i++) begin
      if (i == change_idx) score2 = 8'd0;
      for (int c = 0; c < exp_q[i].n; c++) begin
        @(posedge clk); #1;
        exp_t = {exp_q[i].st, exp_q[i].dig, exp_q[i].sel, exp_q[i].ply, (c == 0) ? exp_q[i].fd : 1'b0};
        got_t = {state2, digit2, 1'b0, sel2, player2, fd2};
        check_count++;
        if (got_t !== exp_t)
          $display("[TB] FAIL small phase %0d cycle %0d: got %h expected %h", i, c, got_t, exp_t);
        else pass_count++;
      end
    end
    enable2 = 1'b0;
  endtask

  task automatic test_score_change();
    logic [13:0] got_t, exp_t;
    int change_idx;
    apply_reset();
    scores1 = {8'd205, 8'd42, 8'd7};
    exp_q.delete();
    push_blinks(4'd0, 1'b0);
    push_phase(2'd3, 4'd7, 3'b001, 4'd0, 1'b0, 5);
    push_blinks(4'd1, 1'b0);
    push_phase(2'd3, 4'd4, 3'b010, 4'd1, 1'b0, 5);
    change_idx = exp_q.size();
    push_phase(2'd3, 4'd2, 3'b001, 4'd1, 1'b0, 5);
    push_blinks(4'd2, 1'b0);
    push_phase(2'd3, 4'd2, 3'b100, 4'd2, 1'b0, 5);
    push_phase(2'd3, 4'd0, 3'b010, 4'd2, 1'b0, 5);
    push_phase(2'd3, 4'd5, 3'b001, 4'd2, 1'b0, 5);
    push_blinks(4'd0, 1'b1);
    push_phase(2'd3, 4'd7, 3'b001, 4'd0, 1'b0, 5);
    push_blinks(4'd1, 1'b0);
    push_phase(2'd3, 4'd9, 3'b010, 4'd1, 1'b0, 5);
    push_phase(2'd3, 4'd9, 3'b001, 4'd1, 1'b0, 5);
    enable1 = 1'b1;
    for (int i = 0; i < exp_q.size(); i++) begin
      if (i == change_idx) scores1[15:8] = 8'd99;
      for (int c = 0; c < exp_q[i].n; c++) begin
        @(posedge clk); #1;
        exp_t = {exp_q[i].st, exp_q[i].dig, exp_q[i].sel, exp_q[i].ply, (c == 0) ? exp_q[i].fd : 1'b0};
        got_t = {state1, digit1, sel1, player1, fd1};
        check_count++;
        if (got_t !== exp_t)
          $display("[TB] FAIL score_change phase %0d cycle %0d: got %h expected %h", i, c, got_t, exp_t);
        else pass_count++;
      end
    end
  endtask

  task automatic test_enable_drop();
    logic [13:0] got_t, exp_t;
    apply_reset();
    scores1 = {8'd205, 8'd42, 8'd7};
    exp_q.delete();
    push_blinks(4'd0, 1'b0);
    push_phase(2'd3, 4'd7, 3'b001, 4'd0, 1'b0, 5);
    push_blinks(4'd1, 1'b0);
    push_phase(2'd3, 4'd4, 3'b010, 4'd1, 1'b0, 5);
    push_phase(2'd3, 4'd2, 3'b001, 4'd1, 1'b0, 5);
    push_blinks(4'd2, 1'b0);
    push_phase(2'd3, 4'd2, 3'b100, 4'd2, 1'b0, 2);
    enable1 = 1'b1;
    for (int i = 0; i < exp_q.size(); i++) begin
      for (int c = 0; c < exp_q[i].n; c++) begin
        @(posedge clk); #1;
        exp_t = {exp_q[i].st, exp_q[i].dig, exp_q[i].sel, exp_q[i].ply, (c == 0) ? exp_q[i].fd : 1'b0};
        got_t = {state1, digit1, sel1, player1, fd1};
        check_count++;
        if (got_t !== exp_t)
          $display("[TB] FAIL enable_run phase %0d cycle %0d: got %h expected %h", i, c, got_t, exp_t);
        else pass_count++;
      end
    end
    enable1 = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      got_t = {state1, digit1, sel1, player1, fd1};
      check_count++;
      if (got_t !== {2'd0, 4'hF, 3'b000, 4'd0, 1'b0})
        $display("[TB] FAIL enable_drop cycle %0d: got %h expected %h", c, got_t, {2'd0, 4'hF, 3'b000, 4'd0, 1'b0});
      else pass_count++;
    end
    enable1 = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      exp_t = (c < 4) ? {2'd1, 4'd1, 3'b001, 4'd0, 1'b0} : {2'd2, 4'hF, 3'b001, 4'd0, 1'b0};
      got_t = {state1, digit1, sel1, player1, fd1};
      check_count++;
      if (got_t !== exp_t)
        $display("[TB] FAIL reenable cycle %0d: got %h expected %h", c, got_t, exp_t);
      else pass_count++;
    end
  endtask

  task automatic test_async_reset();
    logic [13:0] got_t, exp_t;
    apply_reset();
    scores1 = {8'd205, 8'd42, 8'd7};
    enable1 = 1'b1;
    for (int c = 0; c < 6; c++) begin
      @(posedge clk); #1;
      exp_t = (c < 4) ? {2'd1, 4'd1, 3'b001, 4'd0, 1'b0} : {2'd2, 4'hF, 3'b001, 4'd0, 1'b0};
      got_t = {state1, digit1, sel1, player1, fd1};
      check_count++;
      if (got_t !== exp_t)
        $display("[TB] FAIL pre_reset cycle %0d: got %h expected %h", c, got_t, exp_t);
      else pass_count++;
    end
    #2 rst = 1'b1;
    #1;
    got_t = {state1, digit1, sel1, player1, fd1};
    check_count++;
    if (got_t !== {2'd0, 4'hF, 3'b000, 4'd0, 1'b0})
      $display("[TB] FAIL async_reset: got %h expected %h", got_t, {2'd0, 4'hF, 3'b000, 4'd0, 1'b0});
    else pass_count++;
    #2 rst = 1'b0;
    exp_q.delete();
    push_blinks(4'd0, 1'b0);
    push_phase(2'd3, 4'd7, 3'b001, 4'd0, 1'b0, 5);
    push_phase(2'd1, 4'd2, 3'b001, 4'd1, 1'b0, 1);
    for (int i = 0; i < exp_q.size(); i++) begin
      for (int c = 0; c < exp_q[i].n; c++) begin
        @(posedge clk); #1;
        exp_t = {exp_q[i].st, exp_q[i].dig, exp_q[i].sel, exp_q[i].ply, (c == 0) ? exp_q[i].fd : 1'b0};
        got_t = {state1, digit1, sel1, player1, fd1};
        check_count++;
        if (got_t !== exp_t)
          $display("[TB] FAIL restart phase %0d cycle %0d: got %h expected %h", i, c, got_t, exp_t);
        else pass_count++;
      end
    end
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    $display("[TB] starting scoreboard_display_sequencer bench");
    test_reset();
    test_frame();
    test_small_display();
    test_score_change();
    test_enable_drop();
    test_async_reset();
    $display("%0d/%0d checks passed", pass_count, check_count);
    $finish;
  end

endmodule

// File: doc/scoreboard_display_sequencer.md
# scoreboard_display_sequencer

Parametrised display sequencer for the scoreboard. It replaces the fixed two-player, two-digit controller and drives the shared digit bus and one-hot digit-select lines of the 7-segment driver. For N players it cycles through each player in turn: blink the player number, then show that player's score most significant digit first, with leading zeros suppressed. The score is converted to BCD sequentially from a per-player snapshot, and values the display cannot show saturate.

## Interface
- N_PLAYERS, 2: number of players, 1..9 (player number shown is 1..N_PLAYERS).
- SCORE_W, 8: width of each score, 1..16.
- N_DIGITS, 3: number of display digits, 1..4; digit 0 = ones.
- BLINK_HALF, 1_048_576: cycles per blink on-phase and per blink off-phase.
- BLINK_COUNT, 3: number of on/off blink pairs per player.
- DIGIT_CYCLES, 1_048_576: cycles each score digit is shown.
- Elaboration check: 2*BLINK_HALF*BLINK_COUNT >= SCORE_W+2.
- clk_i  in  1  clock.
- rst_i  in  1  reset, asynchronous, active-high.
- enable_i  in  1  run; low forces IDLE and a blank display.
- scores_i  in  N_PLAYERS*SCORE_W  packed scores; player p is at bits [p*SCORE_W +: SCORE_W].
- digit_o  out  4  BCD digit or player number; 4'hF = blank.
- segment_select_o  out  N_DIGITS  one-hot digit enable; all zero = none.
- player_o  out  4  index of the player being sequenced, 0-based.
- state_o  out  2  current state: 0 IDLE, 1 BLINK_ON, 2 BLINK_OFF, 3 DIGIT.
- frame_done_o  out  1  one-cycle pulse when all players have been shown.

## Operation
- IDLE
  - digit_o=4'hF, segment_select_o=0, player_o=0.
  - When enable_i is sampled high, go to BLINK_ON with player 0.
- Entering BLINK_ON for a player's first pulse
  - Snapshot that player's score slice.
  - Start a double-dabble BCD conversion: SCORE_W shift cycles plus 1 finalise cycle.
  - The snapshot is held until the next player starts; later changes on scores_i are ignored.
- Saturation: if the snapshot exceeds 10^N_DIGITS-1, every BCD digit becomes 9.
- BLINK_ON: digit_o = player_o+1, segment_select_o = 1 (digit 0). Lasts BLINK_HALF cycles, then go to BLINK_OFF.
- BLINK_OFF: digit_o=4'hF, segment_select_o = 1. Lasts BLINK_HALF cycles.
  - After the BLINK_COUNT-th off-phase, go to DIGIT.
  - Otherwise go back to BLINK_ON.
- DIGIT
  - Start at the highest non-zero BCD digit; digit 0 is always shown, so score 0 shows "0".
  - digit_o = BCD[k], segment_select_o = 1<<k. Each digit lasts DIGIT_CYCLES cycles, then k decrements.
  - After digit 0, go to BLINK_ON for the next player.
  - From the last player, wrap to player 0 and pulse frame_done_o in that wrap cycle.
- When enable_i is sampled low in any state, go to IDLE on the next edge and clear all timers and counters. Re-enabling always restarts at player 0.
- Asynchronous reset mid-operation returns everything to IDLE values immediately. No partial frame resumes.

## Timing
- Reset values: state_o=0, digit_o=4'hF, segment_select_o=0, player_o=0, frame_done_o=0; all counters and the snapshot are 0.
- All outputs are registered and change only on clk_i edges, except the asynchronous reset.
- Start-up: enable_i high at edge t puts the block in BLINK_ON at t+1.
- Per-player duration: 2*BLINK_HALF*BLINK_COUNT + DIGIT_CYCLES*D cycles, where D = number of digits shown.
- BCD conversion completes at least 1 cycle before DIGIT is entered (guaranteed by the elaboration check).
- frame_done_o is high for exactly 1 cycle per frame, and never in IDLE.
- Counters are sized to their parameter; no wrap-around occurs inside a phase.

## Test plan
Bench parameters for scenarios 1, 2, 4, 5, 6: N_PLAYERS=3, N_DIGITS=3, BLINK_HALF=4, BLINK_COUNT=2, DIGIT_CYCLES=5.
1. Reset with enable_i=0 -> all outputs at reset values. Hold for 50 cycles -> they stay there.
2. Scores 7, 42, 205, enable_i high -> the following sequence, with frame_done_o=1 for 1 cycle at the return to player 0:
   - player 0: "1" on, blank, "1" on, blank (4 cycles each), then 7 on select 001 for 5 cycles (21 cycles total);
   - player 1: "2" blinks, then 4 on 010, then 2 on 001;
   - player 2: "3" blinks, then 2 on 100, 0 on 010, 5 on 001.
3. Instance with N_DIGITS=2, one player at score 255 -> shows 9 on select 10, then 9 on select 01. Score 0 -> only "0" on select 01.
4. Change player 1's score from 42 to 99 during its DIGIT phase -> 4, 2 still shown. The next frame shows 9, 9.
5. Drop enable_i during player 2's DIGIT phase -> next cycle IDLE and blank. Re-enable -> BLINK_ON with player 0.
6. Assert rst_i asynchronously mid-BLINK_OFF -> outputs take reset values without a clock edge. Release rst_i with enable_i high -> sequence restarts at player 0.
